// File: rtl/gpio_pad_mode_sequencer.sv
// gpio_pad_mode_sequencer: sequences per-pad GPIO mode changes break-before-make after a power-on hold
module gpio_pad_mode_sequencer #(
    parameter int NUM_PADS      = 44,
    parameter int SETTLE_CYCLES = 4,
    parameter int POR_HOLD      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [5:0]          cmd_pad,
    input  logic [2:0]          cmd_mode,
    input  logic                cmd_slow,
    output logic                cmd_err,
    output logic                busy,
    output logic [NUM_PADS-1:0] gpio_dm0,
    output logic [NUM_PADS-1:0] gpio_dm1,
    output logic [NUM_PADS-1:0] gpio_dm2,
    output logic [NUM_PADS-1:0] gpio_oeb,
    output logic [NUM_PADS-1:0] gpio_inp_dis,
    output logic [NUM_PADS-1:0] gpio_slow_sel
);
    localparam int HW = $clog2(POR_HOLD + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    typedef enum logic [1:0] {HOLD, IDLE, SETTLE} state_t;
    state_t state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [NUM_PADS-1:0] dm0_q, dm0_d, dm1_q, dm1_d, dm2_q, dm2_d;
    logic [NUM_PADS-1:0] oeb_q, oeb_d, inp_q, inp_d, slow_q, slow_d;
    logic [5:0] pad_q, pad_d;
    logic [2:0] pdm_q, pdm_d;
    logic poeb_q, poeb_d, pinp_q, pinp_d, pslow_q, pslow_d, err_q, err_d;
    logic [2:0] c_dm;
    logic c_oeb, c_inp, c_bad;
    assign c_dm  = cmd_mode == 3'd0 ? 3'b001 : cmd_mode == 3'd3 ? 3'b000 : 3'b110;
    assign c_oeb = cmd_mode == 3'd0 || cmd_mode == 3'd3;
    assign c_inp = cmd_mode == 3'd2 || cmd_mode == 3'd3;
    assign c_bad = cmd_mode[2] || int'(cmd_pad) >= NUM_PADS;
    // Next state: hold countdown, command classification, phase 1 on accept and phase 2 at end of settle
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        dm0_d   = dm0_q;
        dm1_d   = dm1_q;
        dm2_d   = dm2_q;
        oeb_d   = oeb_q;
        inp_d   = inp_q;
        slow_d  = slow_q;
        pad_d   = pad_q;
        pdm_d   = pdm_q;
        poeb_d  = poeb_q;
        pinp_d  = pinp_q;
        pslow_d = pslow_q;
        err_d   = 1'b0;
        case (state_q)
            HOLD: begin
                hold_d = hold_q + 1'b1;
                if (hold_q == HW'(POR_HOLD - 1)) state_d = IDLE;
            end
            IDLE: if (cmd_valid) begin
                if (c_bad) err_d = 1'b1;
                else begin
                    pad_d   = cmd_pad;
                    pdm_d   = c_dm;
                    poeb_d  = c_oeb;
                    pinp_d  = c_inp;
                    pslow_d = cmd_slow;
                    if (c_oeb == oeb_q[cmd_pad]) begin
                        {dm2_d[cmd_pad], dm1_d[cmd_pad], dm0_d[cmd_pad]} = c_dm;
                        oeb_d[cmd_pad]  = c_oeb;
                        inp_d[cmd_pad]  = c_inp;
                        slow_d[cmd_pad] = cmd_slow;
                    end else begin
                        state_d = SETTLE;
                        cnt_d   = SW'(SETTLE_CYCLES - 1);
                        // Driver turns off first on disable; pad is configured first on enable
                        if (c_oeb) oeb_d[cmd_pad] = 1'b1;
                        else begin
                            {dm2_d[cmd_pad], dm1_d[cmd_pad], dm0_d[cmd_pad]} = c_dm;
                            inp_d[cmd_pad]  = c_inp;
                            slow_d[cmd_pad] = cmd_slow;
                        end
                    end
                end
            end
            SETTLE: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    {dm2_d[pad_q], dm1_d[pad_q], dm0_d[pad_q]} = pdm_q;
                    oeb_d[pad_q]  = poeb_q;
                    inp_d[pad_q]  = pinp_q;
                    slow_d[pad_q] = pslow_q;
                end
            end
            default: state_d = HOLD;
        endcase
    end
    // State registers; reset parks every pad as a plain input and restarts the hold window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HOLD;
            hold_q  <= '0;
            cnt_q   <= '0;
            dm0_q   <= '1;
            dm1_q   <= '0;
            dm2_q   <= '0;
            oeb_q   <= '1;
            inp_q   <= '0;
            slow_q  <= '0;
            pad_q   <= '0;
            pdm_q   <= '0;
            poeb_q  <= 1'b0;
            pinp_q  <= 1'b0;
            pslow_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            dm0_q   <= dm0_d;
            dm1_q   <= dm1_d;
            dm2_q   <= dm2_d;
            oeb_q   <= oeb_d;
            inp_q   <= inp_d;
            slow_q  <= slow_d;
            pad_q   <= pad_d;
            pdm_q   <= pdm_d;
            poeb_q  <= poeb_d;
            pinp_q  <= pinp_d;
            pslow_q <= pslow_d;
            err_q   <= err_d;
        end
    end
    assign cmd_ready     = state_q == IDLE;
    assign busy          = state_q != IDLE;
    assign cmd_err       = err_q;
    assign gpio_dm0      = dm0_q;
    assign gpio_dm1      = dm1_q;
    assign gpio_dm2      = dm2_q;
    assign gpio_oeb      = oeb_q;
    assign gpio_inp_dis  = inp_q;
    assign gpio_slow_sel = slow_q;
endmodule

// File: tb/tb_gpio_pad_mode_sequencer.sv
// tb_gpio_pad_mode_sequencer: scoreboard bench with a per-pad mode model for gpio_pad_mode_sequencer
module tb_gpio_pad_mode_sequencer;
    localparam int NP = 44;
    localparam int SETTLE = 4;
    localparam int HOLDN = 16;
    typedef struct packed {
        logic ready, err, busy;
        logic [NP-1:0] dm0, dm1, dm2, oeb, inp, slow;
    } exp_t;
    logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_slow = 1'b0;
    logic [5:0] cmd_pad = '0;
    logic [2:0] cmd_mode = '0;
    logic cmd_ready, cmd_err, busy;
    logic [NP-1:0] gpio_dm0, gpio_dm1, gpio_dm2, gpio_oeb, gpio_inp_dis, gpio_slow_sel;
    int tests = 0, fails = 0;
    exp_t q[$];
    exp_t e;
    int m_mode[NP];
    bit m_slow[NP];
    int hold_left, st_pad, st_mode, st_k;
    bit st_act, st_slow, m_err;

    gpio_pad_mode_sequencer #(.NUM_PADS(NP), .SETTLE_CYCLES(SETTLE), .POR_HOLD(HOLDN)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_pad(cmd_pad),
        .cmd_mode(cmd_mode), .cmd_slow(cmd_slow), .cmd_err(cmd_err), .busy(busy),
        .gpio_dm0(gpio_dm0), .gpio_dm1(gpio_dm1), .gpio_dm2(gpio_dm2), .gpio_oeb(gpio_oeb),
        .gpio_inp_dis(gpio_inp_dis), .gpio_slow_sel(gpio_slow_sel));

    always #5 clk = ~clk;

    function automatic logic [2:0] dm_of(int m);
        return m == 0 ? 3'b001 : m == 3 ? 3'b000 : 3'b110;
    endfunction
    function automatic bit oeb_of(int m);
        return m == 0 || m == 3;
    endfunction
    function automatic bit inp_of(int m);
        return m >= 2;
    endfunction
    function automatic bit m_ready();
        return hold_left == 0 && !st_act;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_mode[p] = 0;
            m_slow[p] = 0;
        end
        hold_left = HOLDN;
        st_act = 0;
        m_err = 0;
    endtask

    task automatic model_edge();
        if (rst) return;
        m_err = 0;
        if (hold_left > 0) hold_left--;
        else if (st_act) begin
            st_k--;
            if (st_k == 0) begin
                m_mode[st_pad] = st_mode;
                m_slow[st_pad] = st_slow;
                st_act = 0;
            end
        end else if (cmd_valid) begin
            if (int'(cmd_pad) >= NP || int'(cmd_mode) >= 4) m_err = 1;
            else if (oeb_of(int'(cmd_mode)) == oeb_of(m_mode[cmd_pad])) begin
                m_mode[cmd_pad] = int'(cmd_mode);
                m_slow[cmd_pad] = cmd_slow;
            end else begin
                st_act = 1;
                st_pad = int'(cmd_pad);
                st_mode = int'(cmd_mode);
                st_slow = cmd_slow;
                st_k = SETTLE;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t x;
        x.ready = m_ready();
        x.busy = !m_ready();
        x.err = m_err;
        for (int p = 0; p < NP; p++) begin
            int m = m_mode[p];
            bit s = m_slow[p];
            bit o = oeb_of(m);
            logic [2:0] d;
            if (st_act && p == st_pad) begin
                if (!oeb_of(st_mode)) begin
                    m = st_mode;
                    s = st_slow;
                end
                o = 1;
            end
            d = dm_of(m);
            {x.dm2[p], x.dm1[p], x.dm0[p]} = d;
            x.oeb[p] = o;
            x.inp[p] = inp_of(m);
            x.slow[p] = s;
        end
        return x;
    endfunction

    task automatic tick(input logic r);
        @(posedge clk);
        #1;
        model_edge();
        rst = r;
        if (r) model_reset();
        q.push_back(model_out());
    endtask

    task automatic send(input int p, input int m, input bit s);
        int n = 0;
        while (!m_ready() && n < 100) begin
            tick(0);
            n++;
        end
        if (n == 100) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: cmd_ready never expected within 100 cycles");
        end
        cmd_valid = 1;
        cmd_pad = 6'(p);
        cmd_mode = 3'(m);
        cmd_slow = s;
        tick(0);
        cmd_valid = 0;
        cmd_pad = 6'($urandom_range(0, 63));
        cmd_mode = 3'($urandom_range(0, 7));
        cmd_slow = 1'($urandom_range(0, 1));
    endtask

    task automatic chk(input string n, input logic [NP-1:0] a, input logic [NP-1:0] x);
        tests++;
        if (a !== x) begin
            fails++;
            $display("FAIL %s at %0t: got %h, expected %h", n, $time, a, x);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("cmd_ready", NP'(cmd_ready), NP'(e.ready));
            chk("cmd_err", NP'(cmd_err), NP'(e.err));
            chk("busy", NP'(busy), NP'(e.busy));
            chk("gpio_dm0", gpio_dm0, e.dm0);
            chk("gpio_dm1", gpio_dm1, e.dm1);
            chk("gpio_dm2", gpio_dm2, e.dm2);
            chk("gpio_oeb", gpio_oeb, e.oeb);
            chk("gpio_inp_dis", gpio_inp_dis, e.inp);
            chk("gpio_slow_sel", gpio_slow_sel, e.slow);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) tick(1);
        tick(0);
        send(5, 1, 1);
        send(5, 3, 1);
        send(7, 3, 0);
        send(8, 0, 0);
        send(44, 1, 0);
        send(3, 5, 0);
        send(8, 0, 1);
        send(12, 2, 0);
        tick(0);
        tick(1);
        tick(1);
        tick(0);
        send(0, 2, 1);
        send(43, 1, 1);
        send(0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                tick(1);
                tick(0);
            end else begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_pad = $urandom_range(0, 4) == 0 ? 6'($urandom_range(44, 63)) : 6'($urandom_range(0, 43));
                cmd_mode = $urandom_range(0, 5) == 0 ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
                cmd_slow = 1'($urandom_range(0, 1));
                tick(0);
            end
        end
        cmd_valid = 0;
        repeat (SETTLE + 2) tick(0);
        @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
